// File: rtl/alu_scheduler.sv
// alu_scheduler
//   Shares one external combinational ALU between N_REQ requesters. Each
//   transaction takes three states. IDLE grants a requester and captures its
//   operands. EXEC samples the ALU output. RESP presents the result until the
//   granted requester accepts it. Arbitration is round-robin: after each
//   response handshake the priority pointer moves to the slot after the one
//   just served.
//
// Parameters
//   N_REQ   number of requesters (2..8)
//   DATA_W  operand / result width (32)
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_valid_i / req_ready_o per-requester request handshake
//   req_a_i, req_b_i, req_op_i per-requester operands and ALU control code
//   resp_valid_o / resp_ready_i per-requester response handshake
//   resp_result_o, resp_zero_o, resp_err_o  shared response payload
//   alu_a_o, alu_b_o, alu_control_o  operands to the external ALU
//   alu_result_i, alu_zero_i  combinational ALU outputs
module alu_scheduler #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_REQ-1:0]              req_valid_i,
  output logic [N_REQ-1:0]              req_ready_o,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_a_i,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_b_i,
  input  logic [N_REQ-1:0][3:0]         req_op_i,
  output logic [N_REQ-1:0]              resp_valid_o,
  input  logic [N_REQ-1:0]              resp_ready_i,
  output logic [DATA_W-1:0]             resp_result_o,
  output logic                          resp_zero_o,
  output logic                          resp_err_o,
  output logic [DATA_W-1:0]             alu_a_o,
  output logic [DATA_W-1:0]             alu_b_o,
  output logic [3:0]                    alu_control_o,
  input  logic [DATA_W-1:0]             alu_result_i,
  input  logic                          alu_zero_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_found;
  logic               req_hs, resp_hs;
  logic [N_REQ-1:0]   req_ready_c, resp_valid_c;

  logic [IDX_W-1:0]   gnt_p0;
  logic [DATA_W-1:0]  a_p0, b_p0;
  logic [3:0]         op_p0;
  logic [DATA_W-1:0]  result_p1;
  logic               zero_p1, err_p1;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (int'(idx) >= N_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  // Round-robin search starting at the priority pointer.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDX_W'(cand);
      if (!gnt_found && req_valid_i[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req_ready_c  = '0;
    resp_valid_c = '0;
    req_hs       = 1'b0;
    resp_hs      = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready_c[gnt_idx] = 1'b1;
          req_hs               = 1'b1;
          state_d              = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        resp_valid_c[gnt_p0] = 1'b1;
        if (resp_ready_i[gnt_p0]) begin
          resp_hs = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset wins over everything, including a handshake in the same cycle.
    if (rst_i) begin
      req_ready_c  = '0;
      resp_valid_c = '0;
      req_hs       = 1'b0;
      resp_hs      = 1'b0;
      state_d      = IDLE;
    end
  end

  // Stage p0: grant and operand capture (IDLE -> EXEC)
  // Stage p1: ALU result capture (EXEC -> RESP)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q     <= '0;
      gnt_p0    <= '0;
      a_p0      <= '0;
      b_p0      <= '0;
      op_p0     <= '0;
      result_p1 <= '0;
      zero_p1   <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      if (req_hs) begin
        gnt_p0 <= gnt_idx;
        a_p0   <= req_a_i[gnt_idx];
        b_p0   <= req_b_i[gnt_idx];
        op_p0  <= req_op_i[gnt_idx];
      end
      if (state_q == EXEC) begin
        result_p1 <= alu_result_i;
        zero_p1   <= alu_zero_i;
        err_p1    <= (op_p0 > 4'd9);
      end
      if (resp_hs) ptr_q <= wrap_inc(gnt_p0);
    end
  end

  // Outputs read as zero for the whole reset cycle, not just after the edge.
  assign req_ready_o   = req_ready_c;
  assign resp_valid_o  = resp_valid_c;
  assign alu_a_o       = rst_i ? '0 : a_p0;
  assign alu_b_o       = rst_i ? '0 : b_p0;
  assign alu_control_o = rst_i ? '0 : op_p0;
  assign resp_result_o = rst_i ? '0 : result_p1;
  assign resp_zero_o   = rst_i ? 1'b0 : zero_p1;
  assign resp_err_o    = rst_i ? 1'b0 : err_p1;

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler
//   Self-checking bench for alu_scheduler with N_REQ=2. Provides a reference
//   ALU on the alu_* ports, runs a table of single transactions with
//   hand-derived results, plus contention, back-pressure and reset-in-RESP
//   sequences. A scoreboard queue holds the expected response of every
//   accepted request and is compared at every response handshake.
module tb_alu_scheduler;

  localparam int N = 2;

  logic                  clk;
  logic                  rst_i;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [N-1:0][31:0]    req_a, req_b;
  logic [N-1:0][3:0]     req_op;
  logic [N-1:0]          resp_valid;
  logic [N-1:0]          resp_ready;
  logic [31:0]           resp_result;
  logic                  resp_zero, resp_err;
  logic [31:0]           alu_a, alu_b, alu_result;
  logic [3:0]            alu_control;
  logic                  alu_zero;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        zero;
    logic        err;
    int          hold;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_log[$];
  vec_t vecs[9];

  alu_scheduler #(.N_REQ(N), .DATA_W(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_a_i       (req_a),
    .req_b_i       (req_b),
    .req_op_i      (req_op),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_result_o (resp_result),
    .resp_zero_o   (resp_zero),
    .resp_err_o    (resp_err),
    .alu_a_o       (alu_a),
    .alu_b_o       (alu_b),
    .alu_control_o (alu_control),
    .alu_result_i  (alu_result),
    .alu_zero_i    (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    logic [31:0] r;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a + b;
      4'd3: r = a ^ b;
      4'd4: r = b << a[4:0];
      4'd5: r = b >> a[4:0];
      4'd6: r = a - b;
      4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: r = ~(a | b);
      4'd9: r = 32'($signed(b) >>> a[4:0]);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, alu_control);
  assign alu_zero   = (alu_result == 32'd0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Observes handshakes that the coming rising edge will complete.
  task automatic monitor();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.idx  = i;
        e.res  = alu_model(req_a[i], req_b[i], req_op[i]);
        e.zero = (e.res == 32'd0);
        e.err  = (req_op[i] > 4'd9);
        exp_q.push_back(e);
        gnt_log.push_back(i);
      end
      if (resp_valid[i] && resp_ready[i]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_resp: actual=response at index %0d required=none", i);
        end else begin
          e = exp_q.pop_front();
          check("sb_idx", 32'(i), 32'(e.idx));
          check("sb_result", resp_result, e.res);
          check("sb_zero", {31'd0, resp_zero}, {31'd0, e.zero});
          check("sb_err", {31'd0, resp_err}, {31'd0, e.err});
        end
      end
    end
  endtask

  // Inputs are driven at the falling edge; sample just before the rising edge.
  task automatic tick();
    #1;
    monitor();
    @(negedge clk);
  endtask

  task automatic do_single(input vec_t v);
    logic [N-1:0] onehot;
    onehot       = N'(1) << v.r;
    req_a[v.r]   = v.a;
    req_b[v.r]   = v.b;
    req_op[v.r]  = v.op;
    req_valid    = onehot;
    resp_ready   = '0;
    #1;
    check("grant_same_cycle", {30'd0, req_ready}, {30'd0, onehot});
    tick();
    req_valid = '0;
    // EXEC
    check("exec_alu_a", alu_a, v.a);
    check("exec_alu_b", alu_b, v.b);
    check("exec_alu_ctrl", {28'd0, alu_control}, {28'd0, v.op});
    check("exec_no_resp", {30'd0, resp_valid}, 32'd0);
    tick();
    // RESP, cycle T+2
    check("resp_latency", {30'd0, resp_valid}, {30'd0, onehot});
    check("vec_result", resp_result, v.res);
    check("vec_zero", {31'd0, resp_zero}, {31'd0, v.zero});
    check("vec_err", {31'd0, resp_err}, {31'd0, v.err});
    for (int h = 0; h < v.hold; h++) begin
      resp_ready = ~onehot;
      req_valid  = ~onehot;
      #1;
      check("bp_ready_low", {30'd0, req_ready}, 32'd0);
      tick();
      check("bp_valid_held", {30'd0, resp_valid}, {30'd0, onehot});
      check("bp_result_held", resp_result, v.res);
    end
    req_valid  = '0;
    resp_ready = onehot;
    tick();
    resp_ready = '0;
    check("resp_done", {30'd0, resp_valid}, 32'd0);
    check("alu_a_hold", alu_a, v.a);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{0, 32'd5,          32'd3,          4'd2,  32'd8,          1'b0, 1'b0, 0};
    vecs[1] = '{0, 32'd7,          32'd7,          4'd6,  32'd0,          1'b1, 1'b0, 5};
    vecs[2] = '{1, 32'd1,          32'd1,          4'd12, 32'd0,          1'b1, 1'b1, 0};
    vecs[3] = '{0, 32'd4,          32'h8000_0000,  4'd9,  32'hF800_0000,  1'b0, 1'b0, 0};
    vecs[4] = '{1, 32'hF0F0_0000,  32'h0FF0_0000,  4'd0,  32'h00F0_0000,  1'b0, 1'b0, 1};
    vecs[5] = '{1, 32'hFFFF_FFFF,  32'd1,          4'd2,  32'd0,          1'b1, 1'b0, 0};
    vecs[6] = '{0, 32'hFFFF_FFFF,  32'd1,          4'd7,  32'd1,          1'b0, 1'b0, 0};
    vecs[7] = '{0, 32'd2,          32'd2,          4'd10, 32'd0,          1'b1, 1'b1, 0};
    vecs[8] = '{1, 32'd3,          32'd3,          4'd15, 32'd0,          1'b1, 1'b1, 0};

    rst_i      = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    @(negedge clk);
    @(negedge clk);
    // Reset state, with requests present that must be ignored.
    req_valid = '1;
    req_a[0]  = 32'h1234_5678;
    #1;
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_ctrl", {28'd0, alu_control}, 32'd0);
    check("rst_result", resp_result, 32'd0);
    check("rst_zero_err", {30'd0, resp_zero, resp_err}, 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst_i     = 1'b0;

    for (int i = 0; i < 9; i++) do_single(vecs[i]);

    // Contention: both requesters always valid, grants must alternate.
    gnt_log.delete();
    req_a[0] = 32'd10; req_b[0] = 32'd1; req_op[0] = 4'd2;
    req_a[1] = 32'd20; req_b[1] = 32'd5; req_op[1] = 4'd6;
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int c = 0; c < 40 && gnt_log.size() < 4; c++) tick();
    req_valid = '0;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) tick();
    check("cont_grant_count", 32'(gnt_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < gnt_log.size(); k++)
      check("cont_grant_order", 32'(gnt_log[k]), 32'(k % 2));
    resp_ready = '0;
    tick();

    // Reset during RESP: pointer is moved to 1 first so the reset is visible.
    v = '{0, 32'd1, 32'd1, 4'd2, 32'd2, 1'b0, 1'b0, 0};
    do_single(v);
    req_a[1]  = 32'd9; req_b[1] = 32'd4; req_op[1] = 4'd2;
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    tick();
    check("pre_rst_resp", {30'd0, resp_valid}, 32'b10);
    rst_i = 1'b1;
    #1;
    check("in_rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    check("in_rst_result", resp_result, 32'd0);
    check("in_rst_alu_a", alu_a, 32'd0);
    tick();
    rst_i = 1'b0;
    exp_q.delete();
    gnt_log.delete();
    check("post_rst_alu_a", alu_a, 32'd0);
    check("post_rst_alu_b", alu_b, 32'd0);
    check("post_rst_alu_ctrl", {28'd0, alu_control}, 32'd0);
    check("post_rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    check("post_rst_result", resp_result, 32'd0);
    req_a[0]   = 32'd6; req_b[0] = 32'd6; req_op[0] = 4'd6;
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    #1;
    check("post_rst_grant", {30'd0, req_ready}, 32'b01);
    tick();
    req_valid = '0;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) tick();
    resp_ready = '0;
    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
